// File: rtl/daq_pkg.sv
// Shared constants, FSM state type and tag-counting helper for the DAQ buffer reader.
package daq_pkg;

  localparam int DAQ_ADDR_W = 15;
  localparam int DAQ_DATA_W = 32;
  localparam int DAQ_RD_LAT = 2;
  localparam int DAQ_TAG_N  = DAQ_RD_LAT + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } daq_state_e;

  // Number of reads still travelling through the buffer read pipeline.
  function automatic logic [3:0] tag_count(input logic [DAQ_TAG_N-1:0] tags);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < DAQ_TAG_N; i++) begin
      n = n + {3'd0, tags[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/daq_rd_fifo.sv
// Output FIFO with a registered head word; an empty FIFO presents a write on the next cycle.
module daq_rd_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   rd_valid,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [OW-1:0]    wr_ptr_r;
  logic [OW-1:0]    rd_ptr_r;
  logic [WIDTH-1:0] out_data_r;
  logic             out_valid_r;
  logic [OW-1:0]    occ_r;
  logic             pop_s;
  logic             refill_s;
  logic             store_empty_s;
  logic             store_wr_s;

  // Head register reloads when empty or consumed; writes bypass storage when it is empty.
  always_comb begin
    pop_s         = out_valid_r & rd_en;
    refill_s      = ~out_valid_r | pop_s;
    store_empty_s = (wr_ptr_r == rd_ptr_r);
    store_wr_s    = wr_en & ~flush & ~(refill_s & store_empty_s);
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (store_wr_s) begin
      mem_r[wr_ptr_r[PW-1:0]] <= wr_data;
    end
  end

  // Pointers, occupancy and head register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r    <= OW'(1'b0);
      rd_ptr_r    <= OW'(1'b0);
      out_data_r  <= WIDTH'(1'b0);
      out_valid_r <= 1'b0;
      occ_r       <= OW'(1'b0);
    end else if (flush) begin
      wr_ptr_r    <= OW'(1'b0);
      rd_ptr_r    <= OW'(1'b0);
      out_data_r  <= WIDTH'(1'b0);
      out_valid_r <= 1'b0;
      occ_r       <= OW'(1'b0);
    end else begin
      occ_r <= occ_r + OW'(wr_en) - OW'(pop_s);
      if (store_wr_s) begin
        wr_ptr_r <= wr_ptr_r + OW'(1'b1);
      end
      if (refill_s) begin
        if (!store_empty_s) begin
          out_data_r  <= mem_r[rd_ptr_r[PW-1:0]];
          out_valid_r <= 1'b1;
          rd_ptr_r    <= rd_ptr_r + OW'(1'b1);
        end else if (wr_en) begin
          out_data_r  <= wr_data;
          out_valid_r <= 1'b1;
        end else begin
          out_valid_r <= 1'b0;
        end
      end
    end
  end

  assign rd_data   = out_data_r;
  assign rd_valid  = out_valid_r;
  assign occupancy = occ_r;

endmodule

// File: rtl/daq_buffer_reader.sv
// Reads an event from a 2-cycle-latency buffer and streams it out with valid/ready,
// using credit accounting so the output FIFO can never overflow.
module daq_buffer_reader
  import daq_pkg::*;
#(
  parameter int ADDR_W     = DAQ_ADDR_W,
  parameter int DATA_W     = DAQ_DATA_W,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   word_count,
  input  logic              abort,
  output logic [ADDR_W-1:0] buf_addr,
  input  logic [DATA_W-1:0] buf_dout,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              dout_last,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;
  localparam int USE_W = OCC_W + 4;

  daq_state_e           state_r;
  logic [ADDR_W-1:0]    buf_addr_r;
  logic [CNT_W-1:0]     rem_r;
  logic                 busy_r;
  logic                 done_r;
  logic [DAQ_TAG_N-1:0] tag_v_r;
  logic [DAQ_TAG_N-1:0] tag_last_r;
  logic                 issue_s;
  logic                 issue_last_s;
  logic                 credit_ok_s;
  logic                 accept_last_s;
  logic [USE_W-1:0]     used_s;
  logic [OCC_W-1:0]     occupancy_s;
  logic                 fifo_valid_s;
  logic [DATA_W:0]      fifo_data_s;

  // Issue decision: a read counts against the FIFO from the moment its address is presented.
  always_comb begin
    used_s        = USE_W'(occupancy_s) + USE_W'(tag_count(tag_v_r));
    credit_ok_s   = (used_s < USE_W'(FIFO_DEPTH));
    accept_last_s = fifo_valid_s & dout_ready & fifo_data_s[DATA_W];
    issue_s       = 1'b0;
    issue_last_s  = 1'b0;
    if (abort) begin
      issue_s      = 1'b0;
      issue_last_s = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start && (word_count != CNT_W'(1'b0))) begin
            issue_s      = 1'b1;
            issue_last_s = (word_count == CNT_W'(1'b1));
          end else begin
            issue_s = 1'b0;
          end
        end
        ST_FETCH: begin
          if ((rem_r != CNT_W'(1'b0)) && credit_ok_s) begin
            issue_s      = 1'b1;
            issue_last_s = (rem_r == CNT_W'(1'b1));
          end else begin
            issue_s = 1'b0;
          end
        end
        default: issue_s = 1'b0;
      endcase
    end
  end

  // Control FSM with registered address, busy and done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      buf_addr_r <= ADDR_W'(1'b0);
      rem_r      <= CNT_W'(1'b0);
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (abort) begin
        state_r <= ST_IDLE;
        busy_r  <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (start && (word_count == CNT_W'(1'b0))) begin
              done_r <= 1'b1;
            end else if (start) begin
              buf_addr_r <= start_addr;
              rem_r      <= word_count - CNT_W'(1'b1);
              state_r    <= ST_FETCH;
              busy_r     <= 1'b1;
            end
          end
          ST_FETCH: begin
            if (rem_r == CNT_W'(1'b0)) begin
              state_r <= ST_DRAIN;
            end else if (issue_s) begin
              buf_addr_r <= buf_addr_r + ADDR_W'(1'b1);
              rem_r      <= rem_r - CNT_W'(1'b1);
              if (rem_r == CNT_W'(1'b1)) begin
                state_r <= ST_DRAIN;
              end
            end
          end
          ST_DRAIN: begin
            if (accept_last_s) begin
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end
          end
          default: begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Tag pipeline: the oldest stage lines up with buf_dout of the matching address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_v_r    <= DAQ_TAG_N'(1'b0);
      tag_last_r <= DAQ_TAG_N'(1'b0);
    end else if (abort) begin
      tag_v_r    <= DAQ_TAG_N'(1'b0);
      tag_last_r <= DAQ_TAG_N'(1'b0);
    end else begin
      tag_v_r    <= {tag_v_r[DAQ_TAG_N-2:0], issue_s};
      tag_last_r <= {tag_last_r[DAQ_TAG_N-2:0], issue_last_s};
    end
  end

  daq_rd_fifo #(
    .WIDTH(DATA_W + 1),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (abort),
    .wr_en    (tag_v_r[DAQ_RD_LAT]),
    .wr_data  ({tag_last_r[DAQ_RD_LAT], buf_dout}),
    .rd_en    (dout_ready),
    .rd_data  (fifo_data_s),
    .rd_valid (fifo_valid_s),
    .occupancy(occupancy_s)
  );

  assign buf_addr   = buf_addr_r;
  assign dout       = fifo_data_s[DATA_W-1:0];
  assign dout_last  = fifo_data_s[DATA_W];
  assign dout_valid = fifo_valid_s;
  assign busy       = busy_r;
  assign done       = done_r;

endmodule

// File: tb/tb_daq_buffer_reader.sv
// Directed bench for daq_buffer_reader with a 2-cycle buffer model and immediate-assertion checks.
module tb_daq_buffer_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [14:0] start_addr;
  logic [15:0] word_count;
  logic        abort;
  logic [14:0] buf_addr;
  logic [31:0] buf_dout;
  logic [31:0] rd_d1;
  logic [31:0] dout;
  logic        dout_valid;
  logic        dout_ready;
  logic        dout_last;
  logic        busy;
  logic        done;

  int vecs = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // Buffer contents: each word carries its own address so wrap and ordering are visible.
  function automatic logic [31:0] mem_word(input logic [14:0] a);
    return {8'hD0, 9'h000, a};
  endfunction

  // Two-cycle read latency buffer model.
  always @(posedge clk) begin
    rd_d1    <= mem_word(buf_addr);
    buf_dout <= rd_d1;
  end

  daq_buffer_reader dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
    .word_count(word_count), .abort(abort), .buf_addr(buf_addr),
    .buf_dout(buf_dout), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .dout_last(dout_last), .busy(busy), .done(done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts an event at the current negedge and collects it until done (bounded).
  task automatic run_event(input string tag, input logic [14:0] a0, input int n,
                           input bit rand_ready, input int busy_start_cyc);
    int got = 0, bad_data = 0, bad_last = 0, bad_hold = 0;
    bit done_seen = 1'b0, prev_stall = 1'b0, prev_last = 1'b0;
    logic [31:0] prev_d = 32'h0;
    logic [14:0] a;
    start = 1'b1; start_addr = a0; word_count = 16'(n); dout_ready = 1'b1;
    for (int cyc = 0; cyc < 3000 && !done_seen; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (cyc == busy_start_cyc) begin
        start = 1'b1; start_addr = 15'h0600; word_count = 16'd7;
      end
      if (prev_stall && (!dout_valid || dout !== prev_d || dout_last !== prev_last)) bad_hold++;
      if (done) done_seen = 1'b1;
      if (rand_ready) dout_ready = (cyc >= 30 && cyc < 50) ? 1'b0 : ($urandom_range(0, 3) != 0);
      else dout_ready = 1'b1;
      if (dout_valid && dout_ready) begin
        a = a0 + 15'(got);
        if (dout !== mem_word(a)) bad_data++;
        if (dout_last !== (got == n - 1)) bad_last++;
        got++;
      end
      prev_stall = dout_valid && !dout_ready;
      prev_d = dout;
      prev_last = dout_last;
    end
    check({tag, "_count"}, got, n);
    check({tag, "_data"}, bad_data, 0);
    check({tag, "_last"}, bad_last, 0);
    check({tag, "_hold"}, bad_hold, 0);
    check({tag, "_done"}, done_seen, 1);
    check({tag, "_busy_end"}, busy, 0);
    check({tag, "_valid_end"}, dout_valid, 0);
  endtask

  initial begin
    logic [14:0] exp_addr [4];
    int bad;
    exp_addr = '{15'h7FFE, 15'h7FFF, 15'h0000, 15'h0001};
    rst = 1'b1; start = 1'b0; abort = 1'b0; dout_ready = 1'b1;
    start_addr = 15'h0; word_count = 16'd0;
    repeat (3) @(negedge clk);
    check("rst_addr", buf_addr, 15'h0);
    check("rst_dout", dout, 32'h0);
    check("rst_valid", dout_valid, 0);
    check("rst_last", dout_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    @(negedge clk);

    // Five words from 0x10: valid at start+4, last on the fifth, done one cycle later.
    start = 1'b1; start_addr = 15'h0010; word_count = 16'd5;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 1) check("A_busy", busy, 1);
      check("A_valid", dout_valid, (c >= 4 && c <= 8));
      if (c >= 4 && c <= 8) begin
        check("A_dout", dout, 32'hD000_0010 + 32'(c - 4));
        check("A_last", dout_last, (c == 8));
      end
      check("A_done", done, (c == 9));
    end
    check("A_busy_end", busy, 0);

    // Address wrap 0x7FFE -> 0x0001.
    start = 1'b1; start_addr = 15'h7FFE; word_count = 16'd4;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c <= 4) check("B_addr", buf_addr, exp_addr[c-1]);
      if (c >= 4 && c <= 7) begin
        check("B_dout", dout, mem_word(exp_addr[c-4]));
        check("B_last", dout_last, (c == 7));
      end
      check("B_done", done, (c == 8));
    end

    // 100 words under random backpressure with a 20-cycle stall.
    run_event("C", 15'h0200, 100, 1'b1, -1);

    // Abort while the third of ten words is on the output.
    @(negedge clk);
    start = 1'b1; start_addr = 15'h0300; word_count = 16'd10; dout_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("D_pre_valid", dout_valid, 1);
    check("D_pre_dout", dout, 32'hD000_0302);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("D_valid", dout_valid, 0);
    check("D_busy", busy, 0);
    check("D_done", done, 0);
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (dout_valid || done) bad++;
    end
    check("D_quiet", bad, 0);
    run_event("D2", 15'h0400, 2, 1'b0, -1);

    // Zero-length request: done only, no data.
    @(negedge clk);
    start = 1'b1; start_addr = 15'h0123; word_count = 16'd0;
    @(negedge clk);
    start = 1'b0;
    check("E0_done", done, 1);
    check("E0_busy", busy, 0);
    check("E0_valid", dout_valid, 0);
    @(negedge clk);
    check("E0_done_end", done, 0);
    check("E0_valid_end", dout_valid, 0);

    // Abort and start together: start ignored.
    start = 1'b1; abort = 1'b1; start_addr = 15'h0123; word_count = 16'd3;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("E1_busy", busy, 0);
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (dout_valid || busy) bad++;
    end
    check("E1_quiet", bad, 0);

    // Start while busy is ignored; current event unaffected.
    run_event("E2", 15'h0500, 3, 1'b0, 1);

    // Async reset in DRAIN.
    @(negedge clk);
    dout_ready = 1'b0;
    start = 1'b1; start_addr = 15'h0700; word_count = 16'd6;
    repeat (10) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("F_pre_busy", busy, 1);
    check("F_pre_valid", dout_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("F_addr", buf_addr, 15'h0);
    check("F_dout", dout, 32'h0);
    check("F_valid", dout_valid, 0);
    check("F_last", dout_last, 0);
    check("F_busy", busy, 0);
    check("F_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    run_event("F2", 15'h0800, 1, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule

// File: doc/daq_buffer_reader.md
DAQ_BUFFER_READER -- requirements
Module: daq_buffer_reader

Interface
REQ-001 SHALL have parameter ADDR_W, default 15, meaning the buffer read-address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning the buffer and stream data width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, meaning the output FIFO entries (power of 2, at least 4).
REQ-004 SHALL have port clk, input, 1, meaning the single clock, also the buffer read clock; there is one clock.
REQ-005 SHALL have port rst, input, 1, meaning reset; reset is asynchronous and active-high.
REQ-006 SHALL have port start, input, 1, meaning a one-cycle request to read an event.
REQ-007 SHALL have port start_addr, input, ADDR_W, meaning the first buffer word of the event.
REQ-008 SHALL have port word_count, input, ADDR_W+1, meaning the number of words to read (0 to 32768).
REQ-009 SHALL have port abort, input, 1, meaning a synchronous cancel of the current read.
REQ-010 SHALL have port buf_addr, output, ADDR_W, meaning the buffer read address (registered).
REQ-011 SHALL have port buf_dout, input, DATA_W, meaning buffer read data, valid exactly 2 clk after buf_addr is presented.
REQ-012 SHALL have port dout, output, DATA_W, meaning the stream data.
REQ-013 SHALL have port dout_valid, output, 1, meaning stream data is valid.
REQ-014 SHALL have port dout_ready, input, 1, meaning the sink accepts data.
REQ-015 SHALL have port dout_last, output, 1, meaning this is the final word of the event.
REQ-016 SHALL have ports busy (output, 1, meaning a read is in progress) and done (output, 1, meaning a one-cycle pulse when the last word is accepted).

Function
REQ-017 SHALL implement the states IDLE, FETCH and DRAIN.
REQ-018 IDLE: on start with word_count>0, SHALL latch the address and count and go to FETCH; on start with word_count=0, SHALL pulse done the next cycle and stay in IDLE.
REQ-019 SHALL ignore start while busy=1.
REQ-020 FETCH: SHALL issue one read per cycle when credit allows (fifo_occupancy + inflight < FIFO_DEPTH), incrementing buf_addr by 1 per issue.
REQ-021 The read address SHALL wrap modulo 2^ADDR_W (32767 -> 0).
REQ-022 FETCH SHALL go to DRAIN in the cycle after the final read issues.
REQ-023 DRAIN SHALL return to IDLE in the cycle the last word is accepted (dout_valid & dout_ready & dout_last); done SHALL pulse in the next cycle.
REQ-024 The read pipeline SHALL tag each in-flight read with a valid bit delayed 2 cycles; tagged buf_dout SHALL be written to the FIFO.
REQ-025 dout_last SHALL be asserted only on the FIFO entry corresponding to the final issued address.
REQ-026 Handshake: dout and dout_last SHALL hold stable while dout_valid=1 and dout_ready=0; dout_valid SHALL NOT deassert without a transfer.
REQ-027 Latency: with dout_ready=1, the first dout_valid SHALL be asserted 4 cycles after the start cycle; sustained throughput SHALL be 1 word/cycle.
REQ-028 The FIFO SHALL never overflow under any dout_ready pattern; credit accounting SHALL guarantee this.
REQ-029 abort SHALL, next cycle, force IDLE, empty the FIFO, discard in-flight data, deassert dout_valid, and not pulse done.
REQ-030 If abort and start occur in the same cycle, abort SHALL win and start SHALL be ignored.
REQ-031 busy SHALL be 1 in FETCH and DRAIN and 0 in IDLE.

Reset
REQ-032 On rst, the block SHALL enter IDLE with buf_addr=0, dout=0, dout_valid=0, dout_last=0, busy=0, done=0, the FIFO empty, and the in-flight tags cleared.
REQ-033 Reset asserted mid-event SHALL discard the event; the block SHALL accept a new start in the first cycle after rst deasserts.

Structure
REQ-034 A shared package daq_pkg SHALL hold DAQ_ADDR_W=15, DAQ_DATA_W=32, DAQ_RD_LAT=2 and the state enumeration type.
REQ-035 A single sub-module daq_rd_fifo (synchronous, registered output, occupancy count, data+last width) SHALL be instantiated; everything else SHALL be inline.

Verification
REQ-036 A bench SHALL cover: start_addr=0x0010, word_count=5, ready=1 -> dout=mem[0x10..0x14] on consecutive cycles, first valid at start+4, last on the 5th word, done one cycle later.
REQ-037 A bench SHALL cover: start_addr=0x7FFE, word_count=4 -> reads 0x7FFE, 0x7FFF, 0x0000, 0x0001 in order.
REQ-038 A bench SHALL cover: word_count=100 with ready toggling randomly (including a 20-cycle stall) -> all 100 words are delivered in order, with no loss or duplication and no FIFO overflow.
REQ-039 A bench SHALL cover: abort at word 3 of 10 -> dout_valid is 0 next cycle with no done pulse, and a following start (count 2) delivers exactly 2 correct words.
REQ-040 A bench SHALL cover: word_count=0 -> no dout_valid and a done pulse one cycle after start; a start during busy -> ignored, with the current event unaffected.
REQ-041 A bench SHALL cover: rst asserted mid-DRAIN -> all outputs return to the reset values of REQ-032 immediately (asynchronously).
